// File: rtl/ram_bist_if.sv
// Single-port RAM bus between the march-test initiator (master) and the RAM (slave).
interface ram_bist_if #(
    parameter int unsigned N = 8,
    parameter int unsigned A = 5
);
    logic         WE;
    logic [A-1:0] Address;
    logic [N-1:0] D;
    logic [N-1:0] Q;

    modport master (output WE, output Address, output D, input Q);
    modport slave  (input WE, input Address, input D, output Q);
endinterface

// File: rtl/ram_bist_ctrl.sv
// March self-test initiator: W0 pattern, R0 check, W1 inverse, R1 check,
// reporting pass/fail plus the first failing address and read data.
module ram_bist_ctrl #(
    parameter int unsigned   N      = 8,
    parameter int unsigned   A      = 5,
    parameter logic [N-1:0]  SEED   = N'(8'hA5),
    parameter int unsigned   RD_LAT = 1
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [A-1:0]  fail_addr,
    output logic [N-1:0]  fail_data,
    ram_bist_if.master    ram
);

    localparam logic [A-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W0,
        S_R0,
        S_W1,
        S_R1,
        S_DONE
    } state_t;

    state_t       r_state,     w_state_nxt;
    logic         r_busy,      w_busy_nxt;
    logic         r_done,      w_done_nxt;
    logic         r_pass,      w_pass_nxt;
    logic [A-1:0] r_fail_addr, w_fail_addr_nxt;
    logic [N-1:0] r_fail_data, w_fail_data_nxt;
    logic         r_we,        w_we_nxt;
    logic [A-1:0] r_addr,      w_addr_nxt;
    logic [N-1:0] r_d,         w_d_nxt;
    logic         r_cmp_vld,   w_cmp_vld_nxt;
    logic [A-1:0] r_cmp_addr,  w_cmp_addr_nxt;
    logic         r_drain,     w_drain_nxt;

    logic [A-1:0] w_cmp_addr;
    logic [N-1:0] w_inv;
    logic [N-1:0] w_exp;
    logic         w_cmp_en;
    logic         w_mismatch;
    logic         w_phase_end;
    logic [A-1:0] w_addr_inc;

    function automatic logic [N-1:0] pat(input logic [A-1:0] a);
        return N'(a) ^ SEED;
    endfunction

    // With a registered RAM read, data is checked one cycle after its address was issued
    assign w_cmp_addr  = (RD_LAT == 0) ? r_addr : r_cmp_addr;
    assign w_cmp_en    = (RD_LAT == 0) ? 1'b1   : r_cmp_vld;
    assign w_phase_end = (RD_LAT == 0) ? (r_addr == LAST_ADDR) : r_drain;
    assign w_inv       = (r_state == S_W1 || r_state == S_R1) ? '1 : '0;
    assign w_exp       = pat(w_cmp_addr) ^ w_inv;
    assign w_mismatch  = w_cmp_en && (ram.Q != w_exp);
    assign w_addr_inc  = r_addr + A'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = r_done;
        w_pass_nxt      = r_pass;
        w_fail_addr_nxt = r_fail_addr;
        w_fail_data_nxt = r_fail_data;
        w_we_nxt        = 1'b0;
        w_addr_nxt      = r_addr;
        w_d_nxt         = '0;
        w_cmp_vld_nxt   = 1'b0;
        w_cmp_addr_nxt  = r_addr;
        w_drain_nxt     = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt     = S_W0;
                    w_busy_nxt      = 1'b1;
                    w_done_nxt      = 1'b0;
                    w_pass_nxt      = 1'b0;
                    w_fail_addr_nxt = '0;
                    w_fail_data_nxt = '0;
                    w_we_nxt        = 1'b1;
                    w_addr_nxt      = '0;
                    w_d_nxt         = pat('0);
                end
            end

            S_W0, S_W1: begin
                w_busy_nxt = 1'b1;
                if (r_addr == LAST_ADDR) begin
                    w_state_nxt = (r_state == S_W0) ? S_R0 : S_R1;
                    w_addr_nxt  = '0;
                end else begin
                    w_we_nxt   = 1'b1;
                    w_addr_nxt = w_addr_inc;
                    w_d_nxt    = pat(w_addr_inc) ^ w_inv;
                end
            end

            S_R0, S_R1: begin
                if (w_mismatch) begin
                    w_state_nxt     = S_DONE;
                    w_done_nxt      = 1'b1;
                    w_pass_nxt      = 1'b0;
                    w_fail_addr_nxt = w_cmp_addr;
                    w_fail_data_nxt = ram.Q;
                    w_addr_nxt      = '0;
                end else if (w_phase_end) begin
                    w_addr_nxt = '0;
                    if (r_state == S_R0) begin
                        w_state_nxt = S_W1;
                        w_busy_nxt  = 1'b1;
                        w_we_nxt    = 1'b1;
                        w_d_nxt     = ~pat('0);
                    end else begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = 1'b1;
                    end
                end else begin
                    // Issue a read; the last address is held through the drain cycle
                    w_busy_nxt    = 1'b1;
                    w_cmp_vld_nxt = 1'b1;
                    w_drain_nxt   = (RD_LAT != 0) && (r_addr == LAST_ADDR);
                    w_addr_nxt    = (r_addr == LAST_ADDR) ? r_addr : w_addr_inc;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_d         <= '0;
            r_cmp_vld   <= 1'b0;
            r_cmp_addr  <= '0;
            r_drain     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_fail_addr <= w_fail_addr_nxt;
            r_fail_data <= w_fail_data_nxt;
            r_we        <= w_we_nxt;
            r_addr      <= w_addr_nxt;
            r_d         <= w_d_nxt;
            r_cmp_vld   <= w_cmp_vld_nxt;
            r_cmp_addr  <= w_cmp_addr_nxt;
            r_drain     <= w_drain_nxt;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail_addr   = r_fail_addr;
    assign fail_data   = r_fail_data;
    assign ram.WE      = r_we;
    assign ram.Address = r_addr;
    assign ram.D       = r_d;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: index 1 uses a registered-read RAM (RD_LAT=1),
// index 0 a combinational-read RAM (RD_LAT=0); results go through a scoreboard.
module tb_ram_bist_ctrl;

    typedef struct {
        int cycles;
        int pass;
        int faddr;
        int fdata;
        int writes;
    } exp_t;

    logic       clk = 1'b0;
    logic [1:0] clear;
    logic [1:0] start;
    logic [1:0] stuck;

    wire       busy_w  [2];
    wire       done_w  [2];
    wire       pass_w  [2];
    wire [4:0] faddr_w [2];
    wire [7:0] fdata_w [2];
    wire       we_w    [2];
    wire [4:0] addr_w  [2];
    wire [7:0] d_w     [2];

    int   vectors = 0;
    int   errs    = 0;
    exp_t sb [2][$];

    bit   active   [2];
    int   cnt      [2];
    int   writes   [2];
    int   viol     [2];
    int   wmis     [2];
    int   done_cnt [2];
    logic prev_done[2];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        ram_bist_if #(.N(8), .A(5)) bus ();
        logic [7:0] mem [32];
        logic [7:0] rd;

        ram_bist_ctrl #(.N(8), .A(5), .SEED(8'hA5), .RD_LAT(k)) dut (
            .clk       (clk),
            .clear     (clear[k]),
            .start     (start[k]),
            .busy      (busy_w[k]),
            .done      (done_w[k]),
            .pass      (pass_w[k]),
            .fail_addr (faddr_w[k]),
            .fail_data (fdata_w[k]),
            .ram       (bus)
        );

        // RAM model with optional bit0 stuck-at-1 at address 5
        assign rd = mem[bus.Address] | ((stuck[k] && bus.Address == 5'd5) ? 8'h01 : 8'h00);
        always @(posedge clk) if (bus.WE) mem[bus.Address] <= bus.D;
        if (k == 1) begin : g_sync
            always @(posedge clk) bus.Q <= rd;
        end else begin : g_comb
            assign bus.Q = rd;
        end

        assign we_w[k]   = bus.WE;
        assign addr_w[k] = bus.Address;
        assign d_w[k]    = bus.D;
    end

    function automatic logic [7:0] model_pat(input logic [4:0] a);
        return 8'(a) ^ 8'hA5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: times each run from its first write to done and pops the scoreboard
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] exp_d;
        for (int k = 0; k < 2; k++) begin
            if (clear[k]) begin
                active[k]    = 1'b0;
                prev_done[k] = 1'b0;
            end else begin
                if (we_w[k] && !active[k]) begin
                    active[k] = 1'b1;
                    cnt[k]    = 0;
                    writes[k] = 0;
                    viol[k]   = 0;
                    wmis[k]   = 0;
                end else if (active[k]) begin
                    cnt[k]++;
                end
                if ((busy_w[k] && done_w[k]) || (we_w[k] && !busy_w[k])) viol[k]++;
                if (active[k] && we_w[k]) begin
                    writes[k]++;
                    exp_d = (writes[k] <= 32) ? model_pat(addr_w[k]) : ~model_pat(addr_w[k]);
                    if (d_w[k] !== exp_d) wmis[k]++;
                    if (addr_w[k] == 5'd3)
                        check($sformatf("d_at_addr3[%0d]", k), 32'(d_w[k]),
                              (writes[k] <= 32) ? 32'hA6 : 32'h59);
                end
                if (done_w[k] === 1'b1 && prev_done[k] !== 1'b1) begin
                    done_cnt[k]++;
                    vectors++;
                    assert (sb[k].size() != 0) else begin
                        errs++;
                        $error("FAIL sb_empty[%0d]: queued 0 expected >0", k);
                    end
                    if (sb[k].size() != 0) begin
                        e = sb[k].pop_front();
                        check($sformatf("cycles[%0d]", k), 32'(cnt[k]), 32'(e.cycles));
                        check($sformatf("pass[%0d]", k), 32'(pass_w[k]), 32'(e.pass));
                        check($sformatf("fail_addr[%0d]", k), 32'(faddr_w[k]), 32'(e.faddr));
                        check($sformatf("fail_data[%0d]", k), 32'(fdata_w[k]), 32'(e.fdata));
                        check($sformatf("writes[%0d]", k), 32'(writes[k]), 32'(e.writes));
                        check($sformatf("write_data_errs[%0d]", k), 32'(wmis[k]), 32'd0);
                        check($sformatf("invariant_errs[%0d]", k), 32'(viol[k]), 32'd0);
                    end
                    active[k] = 1'b0;
                end
                prev_done[k] = done_w[k];
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_run(input int k, input bit push, input exp_t e);
        start[k] = 1'b1;
        if (push) sb[k].push_back(e);
        tick();
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int target, input int budget);
        int n = 0;
        while (done_cnt[k] < target && n < budget) begin
            tick();
            n++;
        end
        check($sformatf("done_reached[%0d]", k), 32'(done_cnt[k] >= target), 32'd1);
    endtask

    function automatic exp_t pass_exp(input int k);
        exp_t e;
        e.cycles = 4 * 32 + 2 * k;
        e.pass   = 1;
        e.faddr  = 0;
        e.fdata  = 0;
        e.writes = 64;
        return e;
    endfunction

    initial begin
        exp_t e;
        int   n;
        for (int k = 0; k < 2; k++) begin
            done_cnt[k] = 0;
            active[k]   = 1'b0;
        end
        stuck = 2'b00;
        clear = 2'b11;
        start = 2'b11;
        @(negedge clk);
        @(negedge clk);
        #1;

        // Reset dominates start: all outputs zero
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_busy[%0d]", k), 32'(busy_w[k]), 32'd0);
            check($sformatf("rst_done[%0d]", k), 32'(done_w[k]), 32'd0);
            check($sformatf("rst_pass[%0d]", k), 32'(pass_w[k]), 32'd0);
            check($sformatf("rst_faddr[%0d]", k), 32'(faddr_w[k]), 32'd0);
            check($sformatf("rst_fdata[%0d]", k), 32'(fdata_w[k]), 32'd0);
            check($sformatf("rst_we[%0d]", k), 32'(we_w[k]), 32'd0);
            check($sformatf("rst_addr[%0d]", k), 32'(addr_w[k]), 32'd0);
            check($sformatf("rst_d[%0d]", k), 32'(d_w[k]), 32'd0);
        end
        clear = 2'b00;
        start = 2'b00;
        repeat (3) tick();
        check("idle_busy[1]", 32'(busy_w[1]), 32'd0);
        check("idle_busy[0]", 32'(busy_w[0]), 32'd0);

        // Good RAM, single start pulse
        start_run(1, 1'b1, pass_exp(1));
        wait_done(1, 1, 300);

        // Stuck bit at address 5 fails in R0, before any W1 write
        stuck[1] = 1'b1;
        e.cycles = 32 + 5 + 2;
        e.pass   = 0;
        e.faddr  = 5;
        e.fdata  = 'hA1;
        e.writes = 32;
        start_run(1, 1'b1, e);
        wait_done(1, 2, 300);
        repeat (3) tick();
        check("fail_held_done", 32'(done_w[1]), 32'd1);
        check("fail_held_addr", 32'(faddr_w[1]), 32'd5);
        check("fail_held_busy", 32'(busy_w[1]), 32'd0);
        stuck[1] = 1'b0;

        // Clear during W0 at address 10 aborts the run
        start_run(1, 1'b0, e);
        n = 0;
        while (!(we_w[1] && addr_w[1] == 5'd10) && n < 100) begin
            tick();
            n++;
        end
        check("w0_addr10_reached", 32'(addr_w[1]), 32'd10);
        clear[1] = 1'b1;
        tick();
        check("abort_we", 32'(we_w[1]), 32'd0);
        check("abort_busy", 32'(busy_w[1]), 32'd0);
        check("abort_addr", 32'(addr_w[1]), 32'd0);
        check("abort_done", 32'(done_w[1]), 32'd0);
        clear[1] = 1'b0;
        tick();
        start_run(1, 1'b1, pass_exp(1));
        wait_done(1, 3, 300);

        // Start pulse during R0 is ignored
        start_run(1, 1'b1, pass_exp(1));
        n = 0;
        while (!(busy_w[1] && !we_w[1]) && n < 100) begin
            tick();
            n++;
        end
        check("in_r0_busy", 32'(busy_w[1]), 32'd1);
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        wait_done(1, 4, 300);

        // Start held high in DONE restarts back to back
        start[1] = 1'b1;
        sb[1].push_back(pass_exp(1));
        sb[1].push_back(pass_exp(1));
        wait_done(1, 6, 600);
        start[1] = 1'b0;
        repeat (3) tick();
        check("after_hold_busy", 32'(busy_w[1]), 32'd0);
        check("after_hold_done", 32'(done_w[1]), 32'd1);

        // Combinational-read build
        start_run(0, 1'b1, pass_exp(0));
        wait_done(0, 1, 300);

        check("sb_drained[1]", 32'(sb[1].size()), 32'd0);
        check("sb_drained[0]", 32'(sb[0].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
